// File: rtl/syn_current_gen.sv
// Spike-driven synaptic current generator: threshold-crossing spike detect,
// weighted integration with saturation, and prescaled exponential decay.
module syn_current_gen #(
    parameter logic signed [7:0] SPIKE_TH    = 8'sd50,
    parameter int unsigned       DECAY_SHIFT = 3,
    parameter int unsigned       DECAY_DIV   = 4,
    parameter logic signed [7:0] W_RESET     = 8'sd16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic signed [7:0] v_pre,
    input  logic signed [7:0] w_data,
    input  logic              w_valid,
    output logic              w_ready,
    output logic signed [7:0] I_syn,
    output logic              spike_out,
    output logic        [7:0] spike_count
);

    localparam logic [7:0] PRESC_MAX = 8'(DECAY_DIV - 1);

    logic signed [7:0] i_syn_q, i_syn_d;
    logic signed [7:0] weight_q, weight_d;
    logic              above_q;
    logic        [7:0] presc_q, presc_d;
    logic              spike_out_q;
    logic        [7:0] count_q, count_d;

    logic              above;
    logic              spike_det;
    logic              tick;
    logic signed [7:0] step;
    logic signed [7:0] dec;
    logic signed [8:0] sum;

    always_comb begin
        above     = (v_pre >= SPIKE_TH);
        spike_det = above & ~above_q;
        tick      = (presc_q == PRESC_MAX);
        presc_d   = tick ? '0 : presc_q + 8'd1;

        // Forcing a minimum step of 1 lets small positive currents reach zero;
        // arithmetic shift already bottoms out at -1 for negative values.
        step = i_syn_q >>> DECAY_SHIFT;
        if (step == '0 && !i_syn_q[7] && i_syn_q != '0) begin
            step = 8'sd1;
        end
        dec = tick ? i_syn_q - step : i_syn_q;

        sum = {dec[7], dec} + (spike_det ? {weight_q[7], weight_q} : 9'sd0);
        if (sum > 9'sd127) begin
            i_syn_d = 8'sd127;
        end else if (sum < -9'sd128) begin
            i_syn_d = -8'sd128;
        end else begin
            i_syn_d = sum[7:0];
        end

        w_ready  = ~spike_det;
        weight_d = (w_valid && w_ready) ? w_data : weight_q;
        count_d  = count_q + {7'd0, spike_det};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            i_syn_q     <= '0;
            weight_q    <= W_RESET;
            above_q     <= 1'b0;
            presc_q     <= '0;
            spike_out_q <= 1'b0;
            count_q     <= '0;
        end else begin
            i_syn_q     <= i_syn_d;
            weight_q    <= weight_d;
            above_q     <= above;
            presc_q     <= presc_d;
            spike_out_q <= spike_det;
            count_q     <= count_d;
        end
    end

    assign I_syn       = i_syn_q;
    assign spike_out   = spike_out_q;
    assign spike_count = count_q;

endmodule

// File: tb/tb_syn_current_gen.sv
// Bench for syn_current_gen: two instances (default and DECAY_DIV=1) driven
// from shared inputs and compared against an integer reference model.
module tb_syn_current_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset;
    logic signed [7:0] v_pre;
    logic signed [7:0] w_data;
    logic              w_valid;

    logic              w_ready   [2];
    logic signed [7:0] isyn      [2];
    logic              spike_out [2];
    logic        [7:0] cnt       [2];

    syn_current_gen dut0 (
        .clk(clk), .reset(reset), .v_pre(v_pre), .w_data(w_data),
        .w_valid(w_valid), .w_ready(w_ready[0]), .I_syn(isyn[0]),
        .spike_out(spike_out[0]), .spike_count(cnt[0])
    );

    syn_current_gen #(.DECAY_DIV(1)) dut1 (
        .clk(clk), .reset(reset), .v_pre(v_pre), .w_data(w_data),
        .w_valid(w_valid), .w_ready(w_ready[1]), .I_syn(isyn[1]),
        .spike_out(spike_out[1]), .spike_count(cnt[1])
    );

    int errors = 0;
    int checks = 0;

    // Reference model state, one slot per instance
    int m_cur [2];
    int m_w   [2];
    int m_ab  [2];
    int m_pre [2];
    int m_cnt [2];
    int m_so  [2];
    int div_of [2] = '{4, 1};

    function automatic int floor_div8(int x);
        if (x >= 0) return x / 8;
        return -((-x + 7) / 8);
    endfunction

    function automatic bit m_spike(int i);
        return (int'(v_pre) >= 50) && (m_ab[i] == 0);
    endfunction

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            bit spk;
            int d, s, stp;
            spk = m_spike(i);
            if (reset) begin
                m_cur[i] = 0; m_w[i] = 16; m_ab[i] = 0;
                m_pre[i] = 0; m_cnt[i] = 0; m_so[i] = 0;
            end else begin
                d = m_cur[i];
                if (m_pre[i] == div_of[i] - 1) begin
                    stp = floor_div8(m_cur[i]);
                    if (stp == 0 && m_cur[i] > 0) stp = 1;
                    d = m_cur[i] - stp;
                end
                s = d + (spk ? m_w[i] : 0);
                if (s > 127) s = 127;
                if (s < -128) s = -128;
                if (w_valid && !spk) m_w[i] = int'(w_data);
                m_cur[i] = s;
                m_ab[i]  = (int'(v_pre) >= 50) ? 1 : 0;
                m_pre[i] = (m_pre[i] + 1) % div_of[i];
                m_cnt[i] = (m_cnt[i] + (spk ? 1 : 0)) % 256;
                m_so[i]  = spk ? 1 : 0;
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; v_pre = -8'sd20; w_valid = 1'b0; w_data = '0;
        cyc(); cyc();
        reset = 1'b0;
        for (int n = 0; n < 20; n++) begin
            cyc();
            checks++;
            if ({isyn[0], cnt[0], spike_out[0], w_ready[0]} !== {8'd0, 8'd0, 1'b0, 1'b1}) begin
                errors++;
                $display("FAIL reset_idle: I_syn=%0d cnt=%0d spike_out=%0b w_ready=%0b, want 0 0 0 1",
                         isyn[0], cnt[0], spike_out[0], w_ready[0]);
            end
        end
    endtask

    task automatic test_single_spike();
        int seen[$];
        int exp_seq[16] = '{16, 14, 13, 12, 11, 10, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0};
        bit ok;
        v_pre = 8'sd50;
        cyc();
        checks++;
        if (isyn[0] !== 8'sd16 || spike_out[0] !== 1'b1 || cnt[0] !== 8'd1) begin
            errors++;
            $display("FAIL single_spike: I_syn=%0d spike_out=%0b cnt=%0d, want 16 1 1",
                     isyn[0], spike_out[0], cnt[0]);
        end
        seen.push_back(int'(isyn[0]));
        v_pre = -8'sd20;
        cyc();
        checks++;
        if (spike_out[0] !== 1'b0) begin
            errors++;
            $display("FAIL single_pulse_width: spike_out=%0b, want 0", spike_out[0]);
        end
        for (int n = 0; n < 200; n++) begin
            if (int'(isyn[0]) != seen[$]) seen.push_back(int'(isyn[0]));
            if (isyn[0] == 0) break;
            cyc();
        end
        ok = (seen.size() == 16);
        if (ok) for (int k = 0; k < 16; k++) if (seen[k] != exp_seq[k]) ok = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL decay_sequence: got %0d distinct values ending at %0d, want 16 values 16..0",
                     seen.size(), seen[$]);
        end
    endtask

    task automatic test_hold();
        logic [7:0] c0;
        c0 = cnt[0];
        v_pre = 8'sd60;
        cyc();
        checks++;
        if (isyn[0] !== 8'sd16) begin
            errors++;
            $display("FAIL hold_first: I_syn=%0d, want 16", isyn[0]);
        end
        for (int n = 0; n < 9; n++) begin
            cyc();
            checks++;
            if (spike_out[0] !== 1'b0 || int'(isyn[0]) != m_cur[0]) begin
                errors++;
                $display("FAIL hold_no_respike: spike_out=%0b I_syn=%0d, want 0 %0d",
                         spike_out[0], isyn[0], m_cur[0]);
            end
        end
        v_pre = -8'sd20; cyc();
        v_pre = 8'sd55;  cyc();
        checks++;
        if (spike_out[0] !== 1'b1 || cnt[0] !== c0 + 8'd2 || int'(isyn[0]) != m_cur[0]) begin
            errors++;
            $display("FAIL hold_second: spike_out=%0b cnt=%0d I_syn=%0d, want 1 %0d %0d",
                     spike_out[0], cnt[0], isyn[0], c0 + 8'd2, m_cur[0]);
        end
        v_pre = -8'sd20; cyc();
    endtask

    task automatic test_saturation();
        w_valid = 1'b1; w_data = 8'sd100; #1;
        checks++;
        if (w_ready[0] !== 1'b1) begin
            errors++;
            $display("FAIL sat_load_ready: w_ready=%0b, want 1", w_ready[0]);
        end
        cyc(); w_valid = 1'b0;
        v_pre = 8'sd60; cyc();
        v_pre = -8'sd20; cyc(); cyc();
        v_pre = 8'sd60; cyc();
        checks++;
        if (isyn[0] !== 8'sd127) begin
            errors++;
            $display("FAIL sat_pos: I_syn=%0d, want 127", isyn[0]);
        end
        v_pre = -8'sd20; w_valid = 1'b1; w_data = -8'sd100; cyc(); w_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            v_pre = 8'sd60; cyc();
            v_pre = -8'sd20; cyc();
        end
        checks++;
        if (isyn[0] !== -8'sd128) begin
            errors++;
            $display("FAIL sat_neg: I_syn=%0d, want -128", isyn[0]);
        end
    endtask

    task automatic wait_zero(input int i, input string tag);
        for (int n = 0; n < 400 && isyn[i] !== 8'sd0; n++) cyc();
        checks++;
        if (isyn[i] !== 8'sd0) begin
            errors++;
            $display("FAIL %s_timeout: I_syn=%0d, want 0", tag, isyn[i]);
        end
    endtask

    task automatic test_handshake();
        v_pre = -8'sd20; w_valid = 1'b1; w_data = 8'sd16; cyc(); w_valid = 1'b0;
        wait_zero(0, "hs_settle");
        v_pre = 8'sd60; w_valid = 1'b1; w_data = 8'sd40; #1;
        checks++;
        if (w_ready[0] !== 1'b0) begin
            errors++;
            $display("FAIL hs_collision_ready: w_ready=%0b, want 0", w_ready[0]);
        end
        cyc();
        checks++;
        if (isyn[0] !== 8'sd16 || spike_out[0] !== 1'b1) begin
            errors++;
            $display("FAIL hs_old_weight: I_syn=%0d spike_out=%0b, want 16 1", isyn[0], spike_out[0]);
        end
        v_pre = -8'sd20; #1;
        checks++;
        if (w_ready[0] !== 1'b1) begin
            errors++;
            $display("FAIL hs_retry_ready: w_ready=%0b, want 1", w_ready[0]);
        end
        cyc(); w_valid = 1'b0;
        wait_zero(0, "hs_settle2");
        v_pre = 8'sd60; cyc();
        checks++;
        if (isyn[0] !== 8'sd40) begin
            errors++;
            $display("FAIL hs_new_weight: I_syn=%0d, want 40", isyn[0]);
        end
        v_pre = -8'sd20; cyc();
    endtask

    task automatic test_reset_midop();
        reset = 1'b1; v_pre = 8'sd60; w_valid = 1'b1; w_data = 8'sd77; #1;
        checks++;
        if (w_ready[0] !== 1'b0) begin
            errors++;
            $display("FAIL rst_ready_follows_spike: w_ready=%0b, want 0", w_ready[0]);
        end
        cyc();
        checks++;
        if ({isyn[0], cnt[0], spike_out[0]} !== {8'd0, 8'd0, 1'b0}) begin
            errors++;
            $display("FAIL rst_midop: I_syn=%0d cnt=%0d spike_out=%0b, want 0 0 0",
                     isyn[0], cnt[0], spike_out[0]);
        end
        v_pre = -8'sd20; cyc();
        reset = 1'b0; w_valid = 1'b0; v_pre = 8'sd60; cyc();
        checks++;
        if (isyn[0] !== 8'sd16 || cnt[0] !== 8'd1 || spike_out[0] !== 1'b1) begin
            errors++;
            $display("FAIL rst_first_spike: I_syn=%0d cnt=%0d spike_out=%0b, want 16 1 1",
                     isyn[0], cnt[0], spike_out[0]);
        end
        v_pre = -8'sd20; cyc();
    endtask

    task automatic test_small_decay();
        int wts[3]  = '{1, -1, -8};
        int nxt[3]  = '{0, 0, -7};
        for (int k = 0; k < 3; k++) begin
            v_pre = -8'sd20; w_valid = 1'b1; w_data = 8'(wts[k]); cyc(); w_valid = 1'b0;
            wait_zero(1, "small_settle");
            v_pre = 8'sd60; cyc();
            checks++;
            if (int'(isyn[1]) != wts[k]) begin
                errors++;
                $display("FAIL small_load: I_syn=%0d, want %0d", isyn[1], wts[k]);
            end
            v_pre = -8'sd20; cyc();
            checks++;
            if (int'(isyn[1]) != nxt[k]) begin
                errors++;
                $display("FAIL small_decay: from %0d got %0d, want %0d", wts[k], isyn[1], nxt[k]);
            end
        end
    endtask

    task automatic test_random();
        int sel;
        for (int n = 0; n < 800; n++) begin
            reset   = ($urandom_range(0, 99) == 0);
            sel     = $urandom_range(0, 5);
            case (sel)
                0: v_pre = -8'sd20;
                1: v_pre = 8'sd49;
                2: v_pre = 8'sd50;
                3: v_pre = 8'sd51;
                4: v_pre = -8'sd128;
                default: v_pre = 8'($urandom);
            endcase
            w_valid = ($urandom_range(0, 3) == 0);
            w_data  = 8'($urandom);
            #1;
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (w_ready[i] !== !m_spike(i)) begin
                    errors++;
                    $display("FAIL rand_w_ready[%0d]: got %0b, want %0b", i, w_ready[i], !m_spike(i));
                end
            end
            cyc();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (int'(isyn[i]) != m_cur[i] || int'(cnt[i]) != m_cnt[i] ||
                    int'(spike_out[i]) != m_so[i]) begin
                    errors++;
                    $display("FAIL rand_outputs[%0d]: I_syn=%0d cnt=%0d spike_out=%0b, want %0d %0d %0d",
                             i, isyn[i], cnt[i], spike_out[i], m_cur[i], m_cnt[i], m_so[i]);
                end
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_spike();
        test_hold();
        test_saturation();
        test_handshake();
        test_reset_midop();
        test_small_decay();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
